// File: rtl/half_fp_pkg.sv
// Shared definitions for the binary16 FP datapath (divider and multiplier).
// Holds the format geometry, canonical special encodings, flag bit positions
// and the divider FSM state type.
package half_fp_pkg;
    localparam int EXP_W  = 5;
    localparam int MAN_W  = 10;
    localparam int BIAS   = 15;
    localparam int FP_W   = 1 + EXP_W + MAN_W;
    // quotient bits: integer, MAN_W fraction, guard, round, plus one spare
    // so a quotient below 1.0 still yields a full significand after the shift
    localparam int QB     = MAN_W + 4;
    localparam int CNT_W  = $clog2(QB);
    localparam int EXP_SW = EXP_W + 2;   // signed working exponent width
    localparam int NFLAGS = 5;

    localparam logic [FP_W-1:0] QNAN = 16'h7E00;
    localparam logic [FP_W-1:0] PINF = 16'h7C00;

    localparam logic signed [EXP_SW-1:0] EXP_TOP = EXP_SW'(2**EXP_W - 1);
    localparam logic signed [EXP_SW-1:0] EXP_ONE = EXP_SW'(1);

    // flags = {invalid, div_by_zero, overflow, underflow, inexact}
    localparam int FLG_INVALID  = 4;
    localparam int FLG_DBZ      = 3;
    localparam int FLG_OVERFLOW = 2;
    localparam int FLG_UNDERFLOW = 1;
    localparam int FLG_INEXACT  = 0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DIVIDE,
        S_ROUND,
        S_DONE
    } state_e;
endpackage

// File: rtl/half_fp_classify.sv
// Combinational binary16 operand classifier.
// Ports:
//   x_i        operand
//   is_zero_o  exponent field zero (denormals count as zero)
//   is_inf_o   infinity
//   is_nan_o   any NaN
//   is_snan_o  signalling NaN (quiet bit clear)
module half_fp_classify
    import half_fp_pkg::*;
(
    input  logic [FP_W-1:0] x_i,
    output logic            is_zero_o,
    output logic            is_inf_o,
    output logic            is_nan_o,
    output logic            is_snan_o
);
    logic [EXP_W-1:0] exp_f;
    logic [MAN_W-1:0] man_f;
    logic             exp_max;
    logic             man_nz;

    assign exp_f   = x_i[FP_W-2 -: EXP_W];
    assign man_f   = x_i[MAN_W-1:0];
    assign exp_max = &exp_f;
    assign man_nz  = |man_f;

    assign is_zero_o = (exp_f == '0);
    assign is_inf_o  = exp_max & ~man_nz;
    assign is_nan_o  = exp_max & man_nz;
    assign is_snan_o = exp_max & man_nz & ~man_f[MAN_W-1];
endmodule

// File: rtl/half_fp_divider.sv
// Iterative binary16 divider: result = a / b.
// Restoring radix-2 mantissa division (one quotient bit per cycle), then a
// single round/pack cycle. Special operands bypass the divider loop.
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   in_valid/in_ready    operand handshake (in_ready high only when idle)
//   a, b                 dividend, divisor
//   out_valid/out_ready  result handshake (result held until out_ready)
//   result               quotient
//   flags                {invalid, div_by_zero, overflow, underflow, inexact}
module half_fp_divider
    import half_fp_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [FP_W-1:0]   a,
    input  logic [FP_W-1:0]   b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [FP_W-1:0]   result,
    output logic [NFLAGS-1:0] flags
);
    localparam int SIG_W = MAN_W + 1;
    localparam int REM_W = MAN_W + 2;   // remainder stays below 2*divisor

    state_e                   state_q, state_d;
    logic [REM_W-1:0]         rem_q, rem_d;
    logic [SIG_W-1:0]         div_q, div_d;
    logic [QB-1:0]            quo_q, quo_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic signed [EXP_SW-1:0] exp_q, exp_d;
    logic                     sign_q, sign_d;
    logic [FP_W-1:0]          result_q, result_d;
    logic [NFLAGS-1:0]        flags_q, flags_d;

    logic za, ia, na, sa, zb, ib, nb, sb;

    half_fp_classify u_cls_a (.x_i(a), .is_zero_o(za), .is_inf_o(ia), .is_nan_o(na), .is_snan_o(sa));
    half_fp_classify u_cls_b (.x_i(b), .is_zero_o(zb), .is_inf_o(ib), .is_nan_o(nb), .is_snan_o(sb));

    // Special-case decode on the live operands, in priority order.
    logic              sign_in, special;
    logic [FP_W-1:0]   spec_res;
    logic [NFLAGS-1:0] spec_flg;

    always_comb begin
        sign_in  = a[FP_W-1] ^ b[FP_W-1];
        special  = 1'b1;
        spec_res = QNAN;
        spec_flg = '0;
        if (na | nb) begin
            spec_flg[FLG_INVALID] = sa | sb;
        end else if ((za & zb) | (ia & ib)) begin
            spec_flg[FLG_INVALID] = 1'b1;
        end else if (zb && !ia) begin
            spec_res = {sign_in, PINF[FP_W-2:0]};
            spec_flg[FLG_DBZ] = 1'b1;
        end else if (ia) begin
            spec_res = {sign_in, PINF[FP_W-2:0]};   // inf/finite and inf/0
        end else if (za | ib) begin
            spec_res = {sign_in, {(FP_W-1){1'b0}}};
        end else begin
            special = 1'b0;
        end
    end

    logic signed [EXP_SW-1:0] exp_in;
    assign exp_in = $signed({2'b00, a[FP_W-2 -: EXP_W]}) - $signed({2'b00, b[FP_W-2 -: EXP_W]})
                  + EXP_SW'(BIAS);

    // One restoring division step.
    logic             ge;
    logic [REM_W-1:0] rem_sub;
    assign ge      = rem_q >= {1'b0, div_q};
    assign rem_sub = ge ? rem_q - {1'b0, div_q} : rem_q;

    // Normalise, round-to-nearest-even, range check and pack.
    logic                     g, r, s, inc, carry;
    logic [SIG_W-1:0]         sig;
    logic [SIG_W:0]           sig_r;
    logic [MAN_W-1:0]         man;
    logic signed [EXP_SW-1:0] exp_n, exp_r;
    logic [FP_W-1:0]          rnd_res;
    logic [NFLAGS-1:0]        rnd_flg;

    always_comb begin
        if (quo_q[QB-1]) begin
            sig   = quo_q[QB-1 -: SIG_W];
            g     = quo_q[2];
            r     = quo_q[1];
            s     = quo_q[0] | (|rem_q);
            exp_n = exp_q;
        end else begin
            // quotient in (0.5,1): bit QB-2 is the leading one
            sig   = quo_q[QB-2 -: SIG_W];
            g     = quo_q[1];
            r     = quo_q[0];
            s     = |rem_q;
            exp_n = exp_q - EXP_ONE;
        end
        inc   = g & (r | s | sig[0]);
        sig_r = {1'b0, sig} + {{SIG_W{1'b0}}, inc};
        carry = sig_r[SIG_W];
        man   = carry ? sig_r[MAN_W:1] : sig_r[MAN_W-1:0];
        exp_r = carry ? exp_n + EXP_ONE : exp_n;

        rnd_flg = '0;
        rnd_flg[FLG_INEXACT] = g | r | s;
        if (exp_r >= EXP_TOP) begin
            rnd_res = {sign_q, PINF[FP_W-2:0]};
            rnd_flg[FLG_OVERFLOW] = 1'b1;
            rnd_flg[FLG_INEXACT]  = 1'b1;
        end else if (exp_r[EXP_SW-1] || exp_r == '0) begin
            rnd_res = {sign_q, {(FP_W-1){1'b0}}};   // flush to signed zero
            rnd_flg[FLG_UNDERFLOW] = 1'b1;
            rnd_flg[FLG_INEXACT]   = 1'b1;
        end else begin
            rnd_res = {sign_q, exp_r[EXP_W-1:0], man};
        end
    end

    always_comb begin
        state_d  = state_q;
        rem_d    = rem_q;
        div_d    = div_q;
        quo_d    = quo_q;
        cnt_d    = cnt_q;
        exp_d    = exp_q;
        sign_d   = sign_q;
        result_d = result_q;
        flags_d  = flags_q;
        unique case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    sign_d = sign_in;
                    if (special) begin
                        result_d = spec_res;
                        flags_d  = spec_flg;
                        state_d  = S_DONE;
                    end else begin
                        rem_d   = {1'b0, 1'b1, a[MAN_W-1:0]};
                        div_d   = {1'b1, b[MAN_W-1:0]};
                        quo_d   = '0;
                        cnt_d   = '0;
                        exp_d   = exp_in;
                        state_d = S_DIVIDE;
                    end
                end
            end
            S_DIVIDE: begin
                rem_d = {rem_sub[SIG_W-1:0], 1'b0};
                quo_d = {quo_q[QB-2:0], ge};
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(QB - 1)) state_d = S_ROUND;
            end
            S_ROUND: begin
                result_d = rnd_res;
                flags_d  = rnd_flg;
                state_d  = S_DONE;
            end
            S_DONE: begin
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            rem_q    <= '0;
            div_q    <= '0;
            quo_q    <= '0;
            cnt_q    <= '0;
            exp_q    <= '0;
            sign_q   <= 1'b0;
            result_q <= '0;
            flags_q  <= '0;
        end else begin
            state_q  <= state_d;
            rem_q    <= rem_d;
            div_q    <= div_d;
            quo_q    <= quo_d;
            cnt_q    <= cnt_d;
            exp_q    <= exp_d;
            sign_q   <= sign_d;
            result_q <= result_d;
            flags_q  <= flags_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign result    = result_q;
    assign flags     = flags_q;
endmodule

// File: tb/tb_half_fp_divider.sv
// Directed bench for half_fp_divider: hand-computed binary16 quotients,
// flags and latencies, handshake stall/ignore behaviour and mid-op reset.
module tb_half_fp_divider;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] result;
    logic [4:0]  flags;

    int checks = 0;
    int errors = 0;

    half_fp_divider dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .flags(flags)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one operation from a post-edge point, wait for the result,
    // optionally stall the consumer and poke in_valid while busy, then retire.
    task automatic do_op(input string tag, input logic [15:0] ta, input logic [15:0] tb_v,
                         input logic [15:0] exp_res, input logic [4:0] exp_flg,
                         input int exp_lat, input int stall, input bit poke);
        int cyc;
        a = ta; b = tb_v; in_valid = 1'b1;
        chk({tag, "_in_ready"}, in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0; a = 16'hDEAD; b = 16'hBEEF;
        cyc = 1;
        while (!out_valid && cyc < 40) begin
            if (poke && cyc == 3) begin in_valid = 1'b1; a = 16'h3C00; b = 16'h0000; end
            if (poke && cyc == 6) in_valid = 1'b0;
            @(posedge clk); #1;
            cyc++;
        end
        in_valid = 1'b0;
        chk({tag, "_latency"}, cyc, exp_lat);
        chk({tag, "_result"}, result, exp_res);
        chk({tag, "_flags"}, flags, exp_flg);
        for (int k = 0; k < stall; k++) begin
            @(posedge clk); #1;
            chk({tag, "_stall_valid"}, out_valid, 1);
            chk({tag, "_stall_ready"}, in_ready, 0);
            chk({tag, "_stall_result"}, result, exp_res);
            chk({tag, "_stall_flags"}, flags, exp_flg);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({tag, "_retired_valid"}, out_valid, 0);
        chk({tag, "_retired_ready"}, in_ready, 1);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_out_valid", out_valid, 0);
        chk("reset_in_ready", in_ready, 1);
        chk("reset_result", result, 16'h0000);
        chk("reset_flags", flags, 5'b00000);
        rst = 1'b0;
        @(posedge clk); #1;

        // normal path, 16-cycle latency
        do_op("div_6_3",      16'h4600, 16'h4200, 16'h4000, 5'b00000, 16, 0, 0);
        do_op("div_1_3",      16'h3C00, 16'h4200, 16'h3555, 5'b00001, 16, 0, 0);
        do_op("div_m1_2",     16'hBC00, 16'h4000, 16'hB800, 5'b00000, 16, 0, 0);
        do_op("div_round_up", 16'h3C03, 16'h3C02, 16'h3C01, 5'b00001, 16, 0, 0);
        do_op("div_sticky",   16'h4000, 16'h3C01, 16'h3FFE, 5'b00001, 16, 0, 0);
        do_op("overflow",     16'h7BFF, 16'h3800, 16'h7C00, 5'b00101, 16, 0, 0);
        do_op("underflow",    16'h0400, 16'h4000, 16'h0000, 5'b00011, 16, 0, 0);

        // special-case fast path, 1-cycle latency
        do_op("div_by_zero",  16'h3C00, 16'h0000, 16'h7C00, 5'b01000, 1, 0, 0);
        do_op("zero_zero",    16'h0000, 16'h0000, 16'h7E00, 5'b10000, 1, 0, 0);
        do_op("snan",         16'h7D00, 16'h3C00, 16'h7E00, 5'b10000, 1, 0, 0);
        do_op("qnan",         16'h7E00, 16'h4000, 16'h7E00, 5'b00000, 1, 0, 0);
        do_op("inf_inf",      16'h7C00, 16'hFC00, 16'h7E00, 5'b10000, 1, 0, 0);
        do_op("ninf_zero",    16'hFC00, 16'h0000, 16'hFC00, 5'b00000, 1, 0, 0);
        do_op("nzero_fin",    16'h8000, 16'h4000, 16'h8000, 5'b00000, 1, 0, 0);
        do_op("fin_inf",      16'hC000, 16'h7C00, 16'h8000, 5'b00000, 1, 0, 0);
        do_op("denorm_daz",   16'h0001, 16'h3C00, 16'h0000, 5'b00000, 1, 0, 0);

        // consumer stall plus in_valid pokes while busy
        do_op("stall_poke",   16'h4600, 16'h4200, 16'h4000, 5'b00000, 16, 5, 1);

        // reset in cycle 7 of a division aborts it
        a = 16'h3C00; b = 16'h4200; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        chk("mid_busy", in_ready, 0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_out_valid", out_valid, 0);
        chk("abort_in_ready", in_ready, 1);
        do_op("after_abort",  16'hBC00, 16'h4000, 16'hB800, 5'b00000, 16, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
